// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- bundle of signals around the VRAM arbiter.
//   Display read port : disp_req, disp_addr -> disp_rvalid, disp_rdata
//   Draw write port   : wr_valid, wr_addr, wr_data -> wr_ready
//   Memory port       : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modport slave is the arbiter's view; master is the view of whoever
// drives the display/draw requests and owns the VRAM macro.
interface vram_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_rvalid, disp_rdata, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_rvalid, disp_rdata, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter -- single-port VRAM slot arbiter for a VGA frame buffer.
// Every cycle one memory slot is granted, in priority order: display read,
// screen-clear write (optional), buffered draw write, else idle. Draw
// writes are queued in a 4-deep FIFO so the draw engine only stalls when
// the queue is full. Display reads return data a fixed 2 cycles after the
// request was sampled (1 register stage + 1-cycle RAM latency).
//
// Ports:
//   clk, rstn     pixel clock, async active-low reset
//   bus (slave)   display read, draw write and memory signals
//   clr_start/clr_color/clr_busy/clr_done  only with VRAM_CLEAR_EN
//
// Build option: define VRAM_CLEAR_EN to add the frame-buffer clear
// sequencer, which fills addresses 0..FB_SIZE-1 with a latched colour.
module vram_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int FB_SIZE = 76800
) (
  input  logic              clk,
  input  logic              rstn,
  vram_arbiter_if.slave     bus
`ifdef VRAM_CLEAR_EN
  ,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done
`endif
);

  localparam int FIFO_D = 4;
  localparam int STAGES = 1;

  if (FB_SIZE < 1 || FB_SIZE > (1 << ADDR_W)) begin : g_fb_size_chk
    $error("FB_SIZE must be in 1..2**ADDR_W");
  end

  // write FIFO
  logic [FIFO_D-1:0][ADDR_W-1:0] f_addr;
  logic [FIFO_D-1:0][DATA_W-1:0] f_data;
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic        push, pop;

  // slot grants
  logic        rd_grant, clr_grant, clr_act;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_col;

  logic [STAGES:0] vld_pipe;

  assign bus.wr_ready = (cnt != 3'(FIFO_D));
  assign push         = bus.wr_valid && bus.wr_ready;

  assign rd_grant  = bus.disp_req;
  assign clr_grant = !bus.disp_req && clr_act;
  // the FIFO is frozen while a clear owns the write slots
  assign pop       = !bus.disp_req && !clr_act && (cnt != 3'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage needs no reset: occupancy gates every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wp] <= bus.wr_addr;
      f_data[wp] <= bus.wr_data;
    end
  end

  // memory command register; mem_addr/mem_wdata hold on idle slots
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      vld_pipe      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_grant};
      if (rd_grant) begin
        bus.mem_en   <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.disp_addr;
      end else if (clr_grant) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= clr_addr;
        bus.mem_wdata <= clr_col;
      end else if (pop) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= f_addr[rp];
        bus.mem_wdata <= f_data[rp];
      end else begin
        bus.mem_en <= 1'b0;
        bus.mem_we <= 1'b0;
      end
    end
  end

  // vld_pipe[STAGES] lines up with the RAM output register, so the read
  // data can be forwarded straight through without another flop.
  assign bus.disp_rvalid = vld_pipe[STAGES];
  assign bus.disp_rdata  = vld_pipe[STAGES] ? bus.mem_rdata : '0;

`ifdef VRAM_CLEAR_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0] clr_st;
  logic       clr_last;

  assign clr_act  = (clr_st == CLEAR);
  assign clr_busy = clr_act;
  assign clr_last = (clr_addr == ADDR_W'(FB_SIZE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_st   <= IDLE;
      clr_addr <= '0;
      clr_col  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (clr_st)
        IDLE: if (clr_start) begin
          clr_col  <= clr_color;
          clr_addr <= '0;
          clr_st   <= CLEAR;
        end
        CLEAR: if (clr_grant) begin
          // stop on the last word rather than wrapping the counter
          if (clr_last) begin
            clr_st   <= IDLE;
            clr_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: clr_st <= IDLE;
      endcase
    end
  end
`else
  assign clr_act  = 1'b0;
  assign clr_addr = '0;
  assign clr_col  = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed bench for vram_arbiter: a vector table for
// single-slot read/write timing, then hand-written sequences for FIFO
// fill/drain, the optional clear sequencer and mid-operation reset.
module tb_vram_arbiter;

  logic clk;
  logic rstn;
  int   tot = 0;
  int   bad = 0;
  int   idx;
  int   dn;

  vram_arbiter_if #(.ADDR_W(17), .DATA_W(12)) bus ();

`ifdef VRAM_CLEAR_EN
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        clr_done;
`endif

  vram_arbiter #(.ADDR_W(17), .DATA_W(12), .FB_SIZE(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef VRAM_CLEAR_EN
    ,
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: 1-cycle read latency, low 8 address bits decoded
  logic [11:0] vmem [0:255];
  always @(posedge clk) begin
    if (!rstn) begin
      vmem[8'h10]   <= 12'hF00;
      vmem[8'h11]   <= 12'h0AB;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_en && bus.mem_we)  vmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= vmem[bus.mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        dr;
    logic [16:0] da;
    logic        wv;
    logic [16:0] wa;
    logic [11:0] wd;
    logic        en;
    logic        we;
    logic [16:0] ad;
    logic [11:0] wdt;
    logic        rv;
    logic [11:0] rd;
    logic        rdy;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(logic dr, logic [16:0] da, logic wv, logic [16:0] wa,
                              logic [11:0] wd, logic en, logic we, logic [16:0] ad,
                              logic [11:0] wdt, logic rv, logic [11:0] rd, logic rdy);
    vec_t v;
    v.dr = dr; v.da = da; v.wv = wv; v.wa = wa; v.wd = wd;
    v.en = en; v.we = we; v.ad = ad; v.wdt = wdt; v.rv = rv; v.rd = rd; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b0;
    clr_color = '0;
`endif
  endtask

  task automatic chk_reset_vals();
    chk("rst_en",    32'(bus.mem_en), 0);
    chk("rst_we",    32'(bus.mem_we), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rv",    32'(bus.disp_rvalid), 0);
    chk("rst_rd",    32'(bus.disp_rdata), 0);
    chk("rst_rdy",   32'(bus.wr_ready), 1);
`ifdef VRAM_CLEAR_EN
    chk("rst_busy",  32'(clr_busy), 0);
    chk("rst_done",  32'(clr_done), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // each row: inputs applied this cycle, outputs expected in this cycle
    vt[0]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 0, 12'h000, 1);
    vt[1]  = mk(1, 17'h10, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 0, 12'h000, 1);
    vt[2]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 1, 0, 17'h10, 12'h000, 0, 12'h000, 1);
    vt[3]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 1, 12'hF00, 1);
    vt[4]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 0, 12'h000, 1);
    vt[5]  = mk(1, 17'h11, 1, 17'h20, 12'h0F0, 0, 0, 17'h00, 12'h000, 0, 12'h000, 1);
    vt[6]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 1, 0, 17'h11, 12'h000, 0, 12'h000, 1);
    vt[7]  = mk(1, 17'h10, 0, 17'h00, 12'h000, 1, 1, 17'h20, 12'h0F0, 1, 12'h0AB, 1);
    vt[8]  = mk(0, 17'h00, 0, 17'h00, 12'h000, 1, 0, 17'h10, 12'h000, 0, 12'h000, 1);
    vt[9]  = mk(1, 17'h11, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 1, 12'hF00, 1);
    vt[10] = mk(0, 17'h00, 0, 17'h00, 12'h000, 1, 0, 17'h11, 12'h000, 0, 12'h000, 1);
    vt[11] = mk(0, 17'h00, 0, 17'h00, 12'h000, 0, 0, 17'h00, 12'h000, 1, 12'h0AB, 1);

    idle();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;

    // single read, then reads interleaved with one buffered write
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("tbl_en", 32'(bus.mem_en), 32'(vt[i].en));
      chk("tbl_we", 32'(bus.mem_we), 32'(vt[i].we));
      if (vt[i].en) chk("tbl_addr", 32'(bus.mem_addr), 32'(vt[i].ad));
      if (vt[i].we) chk("tbl_wdata", 32'(bus.mem_wdata), 32'(vt[i].wdt));
      chk("tbl_rv", 32'(bus.disp_rvalid), 32'(vt[i].rv));
      if (vt[i].rv) chk("tbl_rd", 32'(bus.disp_rdata), 32'(vt[i].rd));
      chk("tbl_rdy", 32'(bus.wr_ready), 32'(vt[i].rdy));
      bus.disp_req  = vt[i].dr;
      bus.disp_addr = vt[i].da;
      bus.wr_valid  = vt[i].wv;
      bus.wr_addr   = vt[i].wa;
      bus.wr_data   = vt[i].wd;
    end

    // fill FIFO behind continuous display reads
    @(negedge clk);
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h10;
    bus.wr_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.wr_addr = 17'(32'h40 + k);
      bus.wr_data = 12'(32'h100 + k);
      chk("fill_rdy", 32'(bus.wr_ready), 32'(k < 4));
      chk("fill_no_we", 32'(bus.mem_we), 0);
      if (k > 0) chk("b2b_rd_en", 32'(bus.mem_en), 1);
      @(negedge clk);
    end
    repeat (2) begin
      chk("hold_rdy", 32'(bus.wr_ready), 0);
      chk("hold_no_we", 32'(bus.mem_we), 0);
      chk("hold_rd_en", 32'(bus.mem_en), 1);
      chk("hold_rv", 32'(bus.disp_rvalid), 1);
      chk("hold_rd", 32'(bus.disp_rdata), 32'h F00);
      @(negedge clk);
    end
    bus.disp_req = 1'b0;
    chk("full_rdy", 32'(bus.wr_ready), 0);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("drain_en", 32'(bus.mem_en), 1);
      chk("drain_we", 32'(bus.mem_we), 1);
      chk("drain_addr", 32'(bus.mem_addr), 32'(32'h40 + j));
      chk("drain_data", 32'(bus.mem_wdata), 32'(32'h100 + j));
      if (j == 0) chk("full_pushpop_rdy", 32'(bus.wr_ready), 1);
      if (j == 1) bus.wr_valid = 1'b0;
      @(negedge clk);
    end
    chk("drained_idle", 32'(bus.mem_en), 0);
    idle();

`ifdef VRAM_CLEAR_EN
    // clear of 16 words with a FIFO write queued alongside
    @(negedge clk);
    clr_start     = 1'b1;
    clr_color     = 12'h00F;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 17'h50;
    bus.wr_data   = 12'h555;
    @(negedge clk);
    clr_start    = 1'b0;
    bus.wr_valid = 1'b0;
    chk("clr_busy_set", 32'(clr_busy), 1);
    idx = 0;
    dn  = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.mem_en && bus.mem_we) begin
        if (idx < 16) begin
          chk("clr_addr", 32'(bus.mem_addr), 32'(idx));
          chk("clr_data", 32'(bus.mem_wdata), 32'h00F);
        end else begin
          chk("post_clr_addr", 32'(bus.mem_addr), 32'h50);
          chk("post_clr_data", 32'(bus.mem_wdata), 32'h555);
        end
        idx++;
      end
      if (clr_done) dn++;
      // a restart request in the middle of a clear must be ignored
      clr_start = (c == 5);
      clr_color = (c == 5) ? 12'hAAA : 12'h00F;
      @(negedge clk);
    end
    chk("clr_write_cnt", 32'(idx), 17);
    chk("clr_done_cnt", 32'(dn), 1);
    chk("clr_busy_end", 32'(clr_busy), 0);
    idle();
`endif

    // reset in the middle of activity with two FIFO entries queued
    @(negedge clk);
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b1;
    clr_color = 12'h0C0;
    @(negedge clk);
    clr_start = 1'b0;
`else
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h10;
`endif
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 17'h60;
    bus.wr_data  = 12'h111;
    @(negedge clk);
    bus.wr_addr  = 17'h61;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", 32'(bus.mem_en), 1);
`ifdef VRAM_CLEAR_EN
    chk("pre_rst_busy", 32'(clr_busy), 1);
`endif
    rstn = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    idle();
    chk_reset_vals();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_en", 32'(bus.mem_en), 0);
      chk("post_rst_rdy", 32'(bus.wr_ready), 1);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
